// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, addresses the instruction ROM, and registers its output into IF/ID.
// Latency: the instruction at PC p appears in IF/ID one cycle after p is on pc_o; one fetch per cycle.
// Backpressure: stall_i holds the PC and IF/ID. Redirect, flush and halt insert bubbles. Halt freezes the stage until rst.
module if_fetch_stage #(
  parameter int          AWIDTH   = 10,
  parameter int          DWIDTH   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              halt_i,
  output logic [AWIDTH-1:0] rom_addr_o,
  input  logic [DWIDTH-1:0] rom_data_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       if_pc_o,
  output logic [DWIDTH-1:0] if_instr_o,
  output logic              if_valid_o,
  output logic              halted_o,
  output logic [31:0]       fetch_count_o
);

  // The PC is always word aligned. Clear the low bits of the reset vector.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_pc_q, if_pc_d;
  logic [DWIDTH-1:0] if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic              halted_q, halted_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  // Next-state selection. Priority is halted > halt_i > redirect > stall > normal.
  always_comb begin
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    if (halted_q) begin
      // Frozen until reset. IF/ID never presents a valid instruction while halted.
      if_valid_d = 1'b0;
    end else if (halt_i) begin
      halted_d   = 1'b1;
      if_valid_d = 1'b0;
    end else if (redirect_i) begin
      // The target is fetched next cycle. The wrong-path slot becomes a bubble.
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end else if (stall_i) begin
      if (flush_i) begin
        if_instr_d = '0;
        if_valid_d = 1'b0;
      end
    end else begin
      pc_d = pc_q + 32'd4;
      if (flush_i) begin
        if_instr_d = '0;
        if_valid_d = 1'b0;
      end else begin
        if_instr_d    = rom_data_i;
        if_pc_d       = pc_q;
        if_valid_d    = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC_ALIGNED;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      if_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // The ROM sees only the registered PC. PCs beyond the ROM depth alias.
  assign rom_addr_o    = pc_q[AWIDTH+1:2];
  assign pc_o          = pc_q;
  assign if_pc_o       = if_pc_q;
  assign if_instr_o    = if_instr_q;
  assign if_valid_o    = if_valid_q;
  assign halted_o      = halted_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam int AWIDTH = 10;
  localparam int DWIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i;
  logic              flush_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              halt_i;
  logic [AWIDTH-1:0] rom_addr_o;
  logic [DWIDTH-1:0] rom_data_i;
  logic [31:0]       pc_o;
  logic [31:0]       if_pc_o;
  logic [DWIDTH-1:0] if_instr_o;
  logic              if_valid_o;
  logic              halted_o;
  logic [31:0]       fetch_count_o;

  logic [DWIDTH-1:0] rom [0:(1<<AWIDTH)-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .pc_o          (pc_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_valid_o    (if_valid_o),
    .halted_o      (halted_o),
    .fetch_count_o (fetch_count_o)
  );

  // Combinational ROM model.
  assign rom_data_i = rom[rom_addr_o];

  typedef struct {
    logic        rst, stall, flush, redir;
    logic [31:0] rpc;
    logic        halt;
    logic [31:0] pc, ipc, instr;
    logic        vld, hlt;
    logic [31:0] cnt;
    logic [9:0]  ra;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic f, logic d, logic [31:0] rp, logic h,
                              logic [31:0] pc, logic [31:0] ipc, logic [31:0] ins,
                              logic v, logic hl, logic [31:0] c, logic [9:0] ra);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.redir = d; t.rpc = rp; t.halt = h;
    t.pc = pc; t.ipc = ipc; t.instr = ins; t.vld = v; t.hlt = hl; t.cnt = c; t.ra = ra;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic [31:0] ins, input logic v, input logic hl,
                           input logic [31:0] c, input logic [9:0] ra);
    chk({tag, ".pc"},       pc_o,          pc);
    chk({tag, ".if_pc"},    if_pc_o,       ipc);
    chk({tag, ".if_instr"}, if_instr_o,    ins);
    chk({tag, ".if_valid"}, {31'b0, if_valid_o}, {31'b0, v});
    chk({tag, ".halted"},   {31'b0, halted_o},   {31'b0, hl});
    chk({tag, ".count"},    fetch_count_o, c);
    chk({tag, ".rom_addr"}, {22'b0, rom_addr_o}, {22'b0, ra});
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic d,
                       input logic [31:0] rp, input logic h);
    rst = r; stall_i = s; flush_i = f; redirect_i = d; redirect_pc_i = rp; halt_i = h;
  endtask

  initial begin
    for (int i = 0; i < (1 << AWIDTH); i++) rom[i] = 32'hC000_0000 | i;
    for (int i = 0; i < 15; i++) rom[i] = 32'h1111_1111 * (i + 1);
    rom[1023] = 32'hDEAD_BEEF;

    drive(1, 0, 0, 0, 0, 0);

    //             rst s f d rpc           h   pc            if_pc         instr         v  hl cnt  ra
    vecs.push_back(mk(1,0,0,0,32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 10'h0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 10'h0));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h4,        32'h0,        32'h1111_1111,1, 0, 1, 10'h1));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h8,        32'h4,        32'h2222_2222,1, 0, 2, 10'h2));
    vecs.push_back(mk(0,1,0,0,32'h0,        0, 32'h8,        32'h4,        32'h2222_2222,1, 0, 2, 10'h2));
    vecs.push_back(mk(0,1,0,0,32'h0,        0, 32'h8,        32'h4,        32'h2222_2222,1, 0, 2, 10'h2));
    vecs.push_back(mk(0,1,0,0,32'h0,        0, 32'h8,        32'h4,        32'h2222_2222,1, 0, 2, 10'h2));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'hC,        32'h8,        32'h3333_3333,1, 0, 3, 10'h3));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h10,       32'hC,        32'h4444_4444,1, 0, 4, 10'h4));
    // redirect to 0x13 while stalled: aligned to 0x10, bubble, if_pc kept
    vecs.push_back(mk(0,1,0,1,32'h13,       0, 32'h10,       32'hC,        32'h0,        0, 0, 4, 10'h4));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h14,       32'h10,       32'h5555_5555,1, 0, 5, 10'h5));
    // unstalled flush: PC advances, bubble, count skips
    vecs.push_back(mk(0,0,1,0,32'h0,        0, 32'h18,       32'h10,       32'h0,        0, 0, 5, 10'h6));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h1C,       32'h18,       32'h7777_7777,1, 0, 6, 10'h7));
    // stall + flush: PC holds, bubble
    vecs.push_back(mk(0,1,1,0,32'h0,        0, 32'h1C,       32'h18,       32'h0,        0, 0, 6, 10'h7));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h20,       32'h1C,       32'h8888_8888,1, 0, 7, 10'h8));
    // redirect to top of address space, then wrap
    vecs.push_back(mk(0,0,0,1,32'hFFFF_FFFE,0, 32'hFFFF_FFFC, 32'h1C,       32'h0,        0, 0, 7, 10'h3FF));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h0,        32'hFFFF_FFFC, 32'hDEAD_BEEF,1, 0, 8, 10'h0));
    vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h4,        32'h0,        32'h1111_1111,1, 0, 9, 10'h1));
    // halt with redirect: redirect ignored, PC held, IF/ID instruction kept, valid dropped
    vecs.push_back(mk(0,0,0,1,32'h100,      1, 32'h4,        32'h0,        32'h1111_1111,0, 1, 9, 10'h1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].instr,
                vecs[i].vld, vecs[i].hlt, vecs[i].cnt, vecs[i].ra);
    end

    // Halted: arbitrary non-reset inputs leave everything frozen for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      check_all($sformatf("halt%0d", i), 32'h4, 32'h0, 32'h1111_1111, 0, 1, 9, 10'h1);
    end

    // Reset out of halt while a redirect and stall are also asserted.
    drive(1, 1, 1, 1, 32'h200, 1);
    @(posedge clk); #1;
    check_all("rst_from_halt", 32'h0, 32'h0, 32'h0, 0, 0, 0, 10'h0);

    // Fetching resumes from the reset vector with the count restarted.
    drive(0, 0, 0, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_all("resume0", 32'h4, 32'h0, 32'h1111_1111, 1, 0, 1, 10'h1);
    @(posedge clk); #1;
    check_all("resume1", 32'h8, 32'h4, 32'h2222_2222, 1, 0, 2, 10'h2);

    // Reset asserted mid-stall clears the pipeline.
    drive(1, 1, 0, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_all("rst_mid_stall", 32'h0, 32'h0, 32'h0, 0, 0, 0, 10'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction ROM. It owns the program counter, drives the ROM word address, and registers the combinational ROM output into the IF/ID pipeline register. It supports stall, flush, branch/jump redirect and halt from downstream stages.

Parameters:
AWIDTH, 10, ROM word-address width (ROM depth = 2**AWIDTH words)
DWIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  hold PC and IF/ID contents
flush_i  input  1  load a bubble into IF/ID
redirect_i  input  1  branch/jump taken; load redirect_pc_i into PC
redirect_pc_i  input  32  redirect target byte address
halt_i  input  1  stop fetching (e.g. syscall exit) until reset
rom_addr_o  output  AWIDTH  word address to ROM raddr
rom_data_i  input  DWIDTH  instruction from ROM dout (combinational, same cycle)
pc_o  output  32  current PC (byte address)
if_pc_o  output  32  PC of instruction held in IF/ID
if_instr_o  output  DWIDTH  instruction held in IF/ID
if_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  sticky halt status
fetch_count_o  output  32  number of instructions delivered into IF/ID

Behaviour:
- One clock; rst is synchronous, active-high; all state updates on rising clk.
- Reset values: pc_o = RESET_PC with bits [1:0] forced to 0; if_pc_o = 0; if_instr_o = 0; if_valid_o = 0; halted_o = 0; fetch_count_o = 0. Reset overrides all other inputs, including mid-stall, mid-redirect or halted.
- rom_addr_o = pc_o[AWIDTH+1:2], combinational. PCs beyond ROM size alias (upper bits dropped); no error flag.
- Latency: instruction at PC p is visible in if_instr_o/if_pc_o the cycle after p appears on pc_o. One instruction per cycle when unstalled.
- Per-cycle priority, highest first: rst > halted > redirect > stall > normal.
- halted_o = 1: PC, if_pc_o, if_instr_o frozen; if_valid_o = 0; fetch_count_o frozen; all other inputs ignored.
- halt_i = 1 (not halted): halted_o <= 1, if_valid_o <= 0, PC holds. halt_i outranks redirect, stall and flush in the same cycle.
- Redirect (regardless of stall): PC <= {redirect_pc_i[31:2],2'b00}; IF/ID <= bubble (if_valid_o <= 0, if_instr_o <= 0, if_pc_o unchanged). The target is fetched next cycle.
- Stall without redirect: PC holds. IF/ID holds, except when flush_i = 1, in which case IF/ID <= bubble.
- Normal (no stall, no redirect): PC <= PC + 4, wrapping modulo 2^32.
  - flush_i = 0: if_instr_o <= rom_data_i, if_pc_o <= PC, if_valid_o <= 1.
  - flush_i = 1: IF/ID <= bubble.
- Bubble encoding: if_instr_o = 32'h0000_0000 (MIPS nop), if_valid_o = 0.
- fetch_count_o increments by 1, wrapping at 2^32, on every edge where if_valid_o is loaded with 1. It does not increment on held or stalled cycles.
- No combinational path from any input to any output except rom_addr_o (from PC register only).

Test Plan:
1. ROM words 0..3 = 0x11111111..0x44444444, rst for 2 cycles then released → pc_o 0,4,8,12. if_instr_o follows one cycle later: 0x11111111 with if_pc_o = 0, then 0x22222222…. fetch_count_o = 4 after 4 fetches.
2. Stall_i high for 3 cycles while if_instr_o = 0x22222222 → pc_o stays 8, IF/ID unchanged, count unchanged. Release → 0x33333333 next cycle.
3. Redirect_i with redirect_pc_i = 0x0000_0013 while stalled → pc_o = 0x10, if_valid_o = 0 next cycle. Following cycle if_instr_o = ROM[4], if_pc_o = 0x10.
4. flush_i for one unstalled cycle → single bubble (if_valid_o = 0, if_instr_o = 0); PC still advances by 4; count skips that slot.
5. halt_i together with redirect_i → halted_o = 1, if_valid_o = 0, PC unchanged (redirect ignored), and state stays frozen for 10 cycles. rst → all outputs return to reset values.
6. Redirect to 0xFFFF_FFFC with AWIDTH = 10 → rom_addr_o = 0x3FF. Next pc_o = 0x0000_0000 (wrap), rom_addr_o = 0.
